// File: rtl/reaction_timer_if.sv
// Signal bundle between the start-light controller side and the reaction timer.
// Names match the timer's external pin names so the board top-level maps 1:1.
interface reaction_timer_if;
    logic        tick_ms;
    logic        arm;
    logic        time_out;
    logic        key_n;
    logic [13:0] result;
    logic        result_valid;
    logic        false_start;
    logic [13:0] best;
    logic        busy;

    modport master (
        output tick_ms, arm, time_out, key_n,
        input  result, result_valid, false_start, best, busy
    );

    modport slave (
        input  tick_ms, arm, time_out, key_n,
        output result, result_valid, false_start, best, busy
    );
endinterface

// File: rtl/reaction_timer.sv
// Reaction timer: synchronised and debounced key, ms counter from lights-out to press,
// false-start detection and best (minimum) time tracking.
module reaction_timer #(
    parameter int MAX_MS      = 9999,
    parameter int DEBOUNCE_MS = 5
) (
    input  logic             clk,
    input  logic             reset,
    reaction_timer_if.slave  rt
);

    localparam int          RUN_W = $clog2(DEBOUNCE_MS + 1);
    localparam logic [13:0] MAX_C = 14'(MAX_MS);

    typedef enum logic [2:0] {IDLE, ARMED, TIMING, DONE, FAULT} state_t;

    function automatic logic [13:0] sat_inc(input logic [13:0] v);
        return (v >= MAX_C) ? MAX_C : v + 14'd1;
    endfunction

    function automatic logic [13:0] min14(input logic [13:0] a, input logic [13:0] b);
        return (a < b) ? a : b;
    endfunction

    logic             key_s1_q, key_s2_q;
    logic             db_q, db_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             press_q, press_d;

    state_t      state_q, state_d;
    logic [13:0] count_q, count_d;
    logic [13:0] result_q, result_d;
    logic        valid_q, valid_d;
    logic        fs_q, fs_d;
    logic [13:0] best_q, best_d;
    logic        done_en;
    logic [13:0] done_val;
    logic [13:0] cnt_inc;

    // Debounce counts only on tick_ms; any matching sample restarts the run.
    always_comb begin
        db_d  = db_q;
        run_d = run_q;
        if (rt.tick_ms) begin
            if (key_s2_q != db_q) begin
                if (run_q == RUN_W'(DEBOUNCE_MS - 1)) begin
                    db_d  = key_s2_q;
                    run_d = '0;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end else begin
                run_d = '0;
            end
        end
        press_d = db_q & ~db_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
            db_q     <= 1'b1;
            run_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            key_s1_q <= rt.key_n;
            key_s2_q <= key_s1_q;
            db_q     <= db_d;
            run_q    <= run_d;
            press_q  <= press_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            best_q   <= MAX_C;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
            best_q   <= best_d;
        end
    end

    // A press wins over a same-cycle tick, so the reported time is the pre-increment count.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        valid_d  = 1'b0;
        fs_d     = fs_q;
        best_d   = best_q;
        done_en  = 1'b0;
        done_val = '0;
        cnt_inc  = sat_inc(count_q);
        case (state_q)
            IDLE: begin
                if (rt.arm) state_d = ARMED;
            end
            ARMED: begin
                if (rt.time_out && press_q) begin
                    done_en  = 1'b1;
                    done_val = '0;
                end else if (press_q) begin
                    state_d = FAULT;
                    fs_d    = 1'b1;
                end else if (rt.time_out) begin
                    state_d = TIMING;
                    count_d = '0;
                end
            end
            TIMING: begin
                if (press_q) begin
                    done_en  = 1'b1;
                    done_val = count_q;
                end else if (rt.tick_ms) begin
                    count_d = cnt_inc;
                    if (cnt_inc == MAX_C) begin
                        done_en  = 1'b1;
                        done_val = MAX_C;
                    end
                end
            end
            DONE: begin
                if (rt.arm) state_d = ARMED;
            end
            FAULT: begin
                if (rt.arm) begin
                    state_d = ARMED;
                    fs_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (done_en) begin
            state_d  = DONE;
            result_d = done_val;
            valid_d  = 1'b1;
            best_d   = min14(best_q, done_val);
        end
    end

    always_comb begin
        rt.busy = (state_q == ARMED) || (state_q == TIMING);
    end

    assign rt.result       = result_q;
    assign rt.result_valid = valid_q;
    assign rt.false_start  = fs_q;
    assign rt.best         = best_q;

endmodule
